// File: rtl/rpll_dyn_ctrl.sv
// Dynamic reconfiguration and lock sequencer for an rPLL: applies a shadowed divider/phase
// config under reset, waits for a debounced lock, retries on timeout and re-arms on lock loss.
//
// state     | meaning
// ----------+------------------------------------------------------------
// APPLY     | PLL held in reset for RST_CYCLES with the shadow config
// WAIT_LOCK | reset released, waiting for LOCK_STABLE clean lock cycles
// LOCKED    | PLL locked, new requests accepted
// FAIL      | retries exhausted, PLL held in reset, new requests accepted
module rpll_dyn_ctrl #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned LOCK_STABLE  = 64,
   parameter int unsigned MAX_RETRY    = 3,
   parameter logic [5:0]  DEF_IDSEL    = 6'd3,
   parameter logic [5:0]  DEF_FBDSEL   = 6'd54,
   parameter logic [5:0]  DEF_ODSEL    = 6'd2,
   parameter logic [3:0]  DEF_PSDA     = 4'd0,
   parameter logic [3:0]  DEF_DUTYDA   = 4'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [5:0] req_idsel,
   input  logic [5:0] req_fbdsel,
   input  logic [5:0] req_odsel,
   input  logic [3:0] req_psda,
   input  logic [3:0] req_dutyda,
   output logic       pll_reset,
   output logic       pll_reset_p,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic [3:0] pll_psda,
   output logic [3:0] pll_dutyda,
   input  logic       pll_lock,
   output logic       locked,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       lock_lost,
   output logic [1:0] retry_cnt
);

   typedef enum logic [1:0] {APPLY, WAIT_LOCK, LOCKED, FAIL} state_t;

   localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TMO_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STABLE_TGT = 16'(LOCK_STABLE);

   state_t      state, state_nx;
   logic [1:0]  lock_sync;
   logic        lock_s;
   logic [15:0] cnt, cnt_inc;
   logic [15:0] stable_cnt, stable_inc, stable_nx;
   logic [1:0]  retry_nx;
   logic [2:0]  retry_sum;
   logic        accept;
   logic        done_set, err_set;

   assign lock_s     = lock_sync[1];
   assign cnt_inc    = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   assign stable_inc = (stable_cnt == 16'hFFFF) ? stable_cnt : stable_cnt + 16'd1;
   assign retry_sum  = {1'b0, retry_cnt} + 3'd1;

   assign req_ready   = (state == LOCKED) || (state == FAIL);
   assign accept      = req_valid && req_ready;
   assign pll_reset   = (state == APPLY) || (state == FAIL);
   assign pll_reset_p = pll_reset;
   assign locked      = (state == LOCKED);
   // Reset parks the FSM in APPLY, so busy is masked while rst is held.
   assign busy        = ((state == APPLY) || (state == WAIT_LOCK)) && !rst;

   always_comb begin
      state_nx  = state;
      retry_nx  = retry_cnt;
      stable_nx = 16'd0;
      lock_lost = 1'b0;
      done_set  = 1'b0;
      err_set   = 1'b0;
      unique case (state)
         APPLY: begin
            if (cnt == RST_LAST) state_nx = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            stable_nx = lock_s ? stable_inc : 16'd0;
            // Lock is checked first so it wins over a coincident timeout.
            if (lock_s && (stable_nx >= STABLE_TGT)) begin
               state_nx = LOCKED;
               retry_nx = 2'd0;
               done_set = 1'b1;
            end else if (cnt == TMO_LAST) begin
               retry_nx = (retry_cnt == 2'd3) ? retry_cnt : retry_sum[1:0];
               if (32'(retry_sum) < MAX_RETRY) begin
                  state_nx = APPLY;
               end else begin
                  state_nx = FAIL;
                  err_set  = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (accept) begin
               state_nx = APPLY;
               retry_nx = 2'd0;
            end else if (!lock_s) begin
               state_nx  = APPLY;
               retry_nx  = 2'd0;
               lock_lost = 1'b1;
            end
         end
         FAIL: begin
            if (accept) begin
               state_nx = APPLY;
               retry_nx = 2'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= APPLY;
         lock_sync  <= 2'b00;
         cnt        <= 16'd0;
         stable_cnt <= 16'd0;
         retry_cnt  <= 2'd0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         lock_sync  <= {lock_sync[0], pll_lock};
         cnt        <= (state_nx != state) ? 16'd0 : cnt_inc;
         stable_cnt <= (state_nx != state) ? 16'd0 : stable_nx;
         retry_cnt  <= retry_nx;
         done       <= done_set;
         err        <= err_set;
      end
   end

   // Shadow config only moves on acceptance, keeping it stable across every reset pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pll_idsel  <= DEF_IDSEL;
         pll_fbdsel <= DEF_FBDSEL;
         pll_odsel  <= DEF_ODSEL;
         pll_psda   <= DEF_PSDA;
         pll_dutyda <= DEF_DUTYDA;
      end else if (accept) begin
         pll_idsel  <= req_idsel;
         pll_fbdsel <= req_fbdsel;
         pll_odsel  <= req_odsel;
         pll_psda   <= req_psda;
         pll_dutyda <= req_dutyda;
      end
   end

endmodule

// File: tb/tb_rpll_dyn_ctrl.sv
// Directed bench for rpll_dyn_ctrl: reset/lock sequencing, reconfiguration, lock loss,
// lock glitch, retry/timeout to FAIL and asynchronous reset mid-sequence.
module tb_rpll_dyn_ctrl;

   localparam int TMO = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [5:0] req_idsel, req_fbdsel, req_odsel;
   logic [3:0] req_psda, req_dutyda;
   logic       pll_reset, pll_reset_p;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [3:0] pll_psda, pll_dutyda;
   logic       pll_lock;
   logic       locked, busy, done, err, lock_lost;
   logic [1:0] retry_cnt;

   logic [25:0] pll_cfg;
   assign pll_cfg = {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda};

   localparam logic [25:0] CFG_DEF = {6'd3, 6'd54, 6'd2, 4'd0, 4'd8};
   localparam logic [25:0] CFG_A   = {6'd1, 6'd10, 6'd4, 4'd5, 4'd7};
   localparam logic [25:0] CFG_B   = {6'd2, 6'd20, 6'd6, 4'd1, 4'd3};
   localparam logic [25:0] CFG_C   = {6'd4, 6'd30, 6'd8, 4'd0, 4'd8};
   localparam logic [25:0] CFG_D   = {6'd20, 6'd40, 6'd10, 4'd15, 4'd15};

   int checks = 0;
   int errors = 0;

   rpll_dyn_ctrl #(.LOCK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_idsel(req_idsel), .req_fbdsel(req_fbdsel), .req_odsel(req_odsel),
      .req_psda(req_psda), .req_dutyda(req_dutyda),
      .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
      .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
      .pll_psda(pll_psda), .pll_dutyda(pll_dutyda),
      .pll_lock(pll_lock),
      .locked(locked), .busy(busy), .done(done), .err(err),
      .lock_lost(lock_lost), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_req(input logic [25:0] c);
      {req_idsel, req_fbdsel, req_odsel, req_psda, req_dutyda} = c;
   endtask

   // Called at a negedge; the request is taken on the following posedge.
   task automatic send_req(input logic [25:0] c);
      set_req(c);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Starts on the first APPLY sample. The PLL model raises lock when reset drops,
   // optionally glitching it low for one cycle glitch_at cycles later.
   task automatic run_relock(input int glitch_at, output int n_rst, output int n_done);
      n_rst = 0;
      while (pll_reset && n_rst < 200) begin
         n_rst++;
         @(negedge clk);
      end
      pll_lock = 1'b1;
      n_done = 0;
      while (!done && n_done < 1000) begin
         @(negedge clk);
         n_done++;
         if (n_done == glitch_at) pll_lock = 1'b0;
         else if (n_done == glitch_at + 1) pll_lock = 1'b1;
      end
   endtask

   task automatic wait_timeout(output int n_rst, output int n_wait);
      n_rst = 0;
      while (pll_reset && n_rst < 200) begin
         n_rst++;
         @(negedge clk);
      end
      n_wait = 0;
      while (!pll_reset && n_wait < 1000) begin
         @(negedge clk);
         n_wait++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr, nd, n;
      rst = 1'b1; pll_lock = 1'b0; req_valid = 1'b0;
      set_req(26'd0);
      repeat (3) @(negedge clk);

      check_val("rst_pll_reset", pll_reset, 1);
      check_val("rst_pll_reset_p", pll_reset_p, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", req_ready, 0);
      check_val("rst_locked", locked, 0);
      check_val("rst_pulses", {done, err, lock_lost}, 0);
      check_val("rst_retry", retry_cnt, 0);
      check_val("rst_cfg", pll_cfg, CFG_DEF);

      // Power-up sequence with default config
      rst = 1'b0;
      #1;
      check_val("pu_busy", busy, 1);
      run_relock(-1, nr, nd);
      check_val("pu_rst_len", nr, 16);
      check_val("pu_done_lat", nd, 66);
      check_val("pu_locked", locked, 1);
      check_val("pu_ready", req_ready, 1);
      check_val("pu_busy_low", busy, 0);
      check_val("pu_pll_reset", {pll_reset, pll_reset_p}, 0);
      @(negedge clk);
      check_val("pu_done_pulse", done, 0);

      // Reconfiguration from LOCKED
      pll_lock = 1'b0;
      send_req(CFG_A);
      check_val("rq_cfg", pll_cfg, CFG_A);
      check_val("rq_pll_reset", pll_reset, 1);
      check_val("rq_busy", busy, 1);
      run_relock(-1, nr, nd);
      check_val("rq_rst_len", nr, 16);
      check_val("rq_done_lat", nd, 66);
      check_val("rq_idsel", pll_idsel, 1);

      // Lock loss, with a request attempted during the recovery sequence
      pll_lock = 1'b0;
      n = 0;
      while (!lock_lost && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("ll_lat", n, 2);
      @(negedge clk);
      check_val("ll_pulse", lock_lost, 0);
      check_val("ll_apply", {pll_reset, locked}, 2'b10);
      check_val("ll_retry", retry_cnt, 0);
      check_val("ll_cfg", pll_cfg, CFG_A);
      set_req(CFG_D);
      req_valid = 1'b1;
      check_val("busy_ready", req_ready, 0);
      run_relock(-1, nr, nd);
      req_valid = 1'b0;
      check_val("ll_rst_len", nr, 16);
      check_val("ll_done_lat", nd, 66);
      check_val("busy_req_ign", pll_cfg, CFG_A);

      // Request coincides with lock loss: request wins, no lock_lost
      pll_lock = 1'b0;
      @(negedge clk);
      check_val("co_early", lock_lost, 0);
      @(negedge clk);
      set_req(CFG_B);
      req_valid = 1'b1;
      #1;
      check_val("co_no_lost", lock_lost, 0);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("co_cfg", pll_cfg, CFG_B);
      check_val("co_apply", pll_reset, 1);

      // Lock glitch at stable count 40
      run_relock(40, nr, nd);
      check_val("gl_rst_len", nr, 16);
      check_val("gl_done_lat", nd, 107);
      check_val("gl_locked", locked, 1);

      // Persistent no-lock: two retries then FAIL
      pll_lock = 1'b0;
      send_req(CFG_C);
      check_val("to_retry0", retry_cnt, 0);
      wait_timeout(nr, nd);
      check_val("to1_rst_len", nr, 16);
      check_val("to1_wait", nd, TMO);
      check_val("to1_retry", retry_cnt, 1);
      check_val("to1_err", err, 0);
      wait_timeout(nr, nd);
      check_val("to2_wait", nd, TMO);
      check_val("to2_retry", retry_cnt, 2);
      check_val("to2_err", err, 0);
      wait_timeout(nr, nd);
      check_val("to3_wait", nd, TMO);
      check_val("fail_err", err, 1);
      check_val("fail_retry", retry_cnt, 3);
      check_val("fail_reset", {pll_reset, pll_reset_p}, 2'b11);
      check_val("fail_locked", locked, 0);
      check_val("fail_ready", req_ready, 1);
      check_val("fail_busy", busy, 0);
      @(negedge clk);
      check_val("fail_err_pulse", err, 0);
      check_val("fail_hold", pll_reset, 1);

      // Recovery request from FAIL
      send_req(CFG_A);
      check_val("fr_cfg", pll_cfg, CFG_A);
      check_val("fr_busy", busy, 1);
      check_val("fr_retry", retry_cnt, 0);
      run_relock(-1, nr, nd);
      check_val("fr_rst_len", nr, 16);
      check_val("fr_done_lat", nd, 66);
      check_val("fr_locked", locked, 1);

      // Asynchronous reset in WAIT_LOCK
      pll_lock = 1'b0;
      send_req(CFG_D);
      n = 0;
      while (pll_reset && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check_val("ar_busy_pre", busy, 1);
      check_val("ar_cfg_pre", pll_cfg, CFG_D);
      #2 rst = 1'b1;
      #1;
      check_val("ar_reset", {pll_reset, pll_reset_p}, 2'b11);
      check_val("ar_cfg", pll_cfg, CFG_DEF);
      check_val("ar_busy", busy, 0);
      check_val("ar_ready", req_ready, 0);
      check_val("ar_locked", locked, 0);
      check_val("ar_flags", {done, err, lock_lost, retry_cnt}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_relock(-1, nr, nd);
      check_val("ar_rst_len", nr, 16);
      check_val("ar_done_lat", nd, 66);
      check_val("ar_relock_cfg", pll_cfg, CFG_DEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpll_dyn_ctrl.md
RPLL_DYN_CTRL -- requirements
Module: rpll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles PLL reset is held per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for a stable lock per attempt.
REQ-003 SHALL have parameter LOCK_STABLE, default 64: number of consecutive synchronized lock-high cycles required to declare lock.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of attempts allowed before failure.
REQ-005 SHALL have parameters DEF_IDSEL, DEF_FBDSEL and DEF_ODSEL (6-bit, defaults 3, 54 and 2) plus DEF_PSDA and DEF_DUTYDA (4-bit, defaults 0 and 8): the configuration applied after reset.
REQ-006 clk  in  1  single clock (PLL reference domain); all logic is on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  1  reconfiguration request.
REQ-009 req_ready  out  1  controller can accept a request.
REQ-010 req_idsel, req_fbdsel, req_odsel  in  6 each  requested divider codes.
REQ-011 req_psda, req_dutyda  in  4 each  requested phase and duty codes.
REQ-012 pll_reset  out  1  drives PLL RESET.
REQ-013 pll_reset_p  out  1  drives PLL RESET_P.
REQ-014 pll_idsel, pll_fbdsel, pll_odsel  out  6 each  drive PLL IDSEL, FBDSEL and ODSEL.
REQ-015 pll_psda, pll_dutyda  out  4 each  drive PLL PSDA and DUTYDA.
REQ-016 pll_lock  in  1  PLL LOCK; asynchronous to clk.
REQ-017 locked  out  1  high while in LOCKED.
REQ-018 busy  out  1  high in APPLY or WAIT_LOCK.
REQ-019 done  out  1  one-cycle pulse on entry to LOCKED.
REQ-020 err  out  1  one-cycle pulse on entry to FAIL.
REQ-021 lock_lost  out  1  one-cycle pulse when lock drops while in LOCKED.
REQ-022 retry_cnt  out  2  attempts consumed in the current sequence.

Function
REQ-023 pll_lock SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-024 States SHALL be APPLY, WAIT_LOCK, LOCKED and FAIL.
REQ-025 APPLY SHALL hold pll_reset=1 and pll_reset_p=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0 and pll_reset_p=0.
REQ-026 pll_* configuration outputs SHALL come from a registered shadow config; the shadow SHALL change only in the cycle a request is accepted, so it is stable across each whole reset pulse.
REQ-027 WAIT_LOCK SHALL count cycles and stable-lock cycles; the stable counter SHALL clear whenever synchronized lock is 0.
REQ-028 When the stable count reaches LOCK_STABLE, WAIT_LOCK SHALL go to LOCKED, pulse done and clear retry_cnt.
REQ-029 On LOCK_TIMEOUT cycles without lock, WAIT_LOCK SHALL increment retry_cnt and re-enter APPLY if retry_cnt+1 < MAX_RETRY; otherwise it SHALL go to FAIL and pulse err.
REQ-030 If stable lock and timeout coincide in the same cycle, lock SHALL win.
REQ-031 FAIL SHALL hold pll_reset=1 and pll_reset_p=1, with locked=0.
REQ-032 req_ready SHALL be 1 only in LOCKED or FAIL; a request is accepted when req_valid&&req_ready.
REQ-033 On acceptance, the controller SHALL latch all req_* fields into the shadow, clear retry_cnt and go to APPLY next cycle.
REQ-034 Requests during APPLY/WAIT_LOCK SHALL not be accepted and SHALL not disturb the sequence.
REQ-035 In LOCKED, synchronized lock = 0 SHALL pulse lock_lost and go to APPLY with the unchanged shadow and retry_cnt=0.
REQ-036 If a request and lock loss occur in the same cycle, the request SHALL be accepted, with the new config applied and no lock_lost pulse.
REQ-037 Codes SHALL pass to the PLL unmodified; encoding validity is the requester's responsibility.
REQ-038 Counters SHALL be 16 bits, saturate rather than wrap, and clear on every state entry.

Reset
REQ-039 While rst=1: state APPLY with counter 0, pll_reset=1, pll_reset_p=1, shadow=DEF_* values, locked=busy=done=err=lock_lost=0, req_ready=0, retry_cnt=0, synchronizer=0.
REQ-040 After rst deasserts, the controller SHALL run APPLY and then WAIT_LOCK with the default config, setting busy=1 from the first cycle.

Verification
REQ-041 Release reset with pll_lock tied high -> pll_reset high for 16 cycles; done pulse 2+64 cycles after entering WAIT_LOCK; locked=1, req_ready=1.
REQ-042 In LOCKED, request idsel=1, fbdsel=10, odsel=4 -> pll_* outputs update before pll_reset rises; relock sequence runs; done pulses; pll_idsel=1.
REQ-043 pll_lock held low -> three timeouts, retry_cnt 1, then 2, then err pulse; FAIL with pll_reset=1; a new request is still accepted.
REQ-044 Drop pll_lock while LOCKED -> lock_lost pulses 2 cycles later; APPLY runs with the same config; relock completes.
REQ-045 Glitch pll_lock low for 1 cycle at stable count 40 -> stable count clears; done pulses only after 64 further clean cycles.
REQ-046 Assert rst mid WAIT_LOCK -> outputs go immediately to reset values; shadow returns to DEF_*.
